// File: rtl/multicycle_datapath.sv
// Multi-cycle 24-bit-instruction datapath: fetch over a request/valid handshake,
// then decode, execute and write back over several cycles.
//
// state       | meaning
// S_FETCH     | fetch_req high, wait for inst_valid, latch IR
// S_DECODE    | read operands into A/B, HALT class exits here
// S_EXECUTE   | ALU op + flag update, or branch-if-zero pc update
// S_WRITEBACK | write alu_res to rd, pc+1
// S_HALT      | absorbing, only reset leaves
module multicycle_datapath #(
  parameter int DATA_W = 24,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fetch_req,
  input  logic              inst_valid,
  input  logic [23:0]       inst,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] alu_res,
  output logic [3:0]        flags,
  output logic              halted,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [23:0]       r_ir;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_regs [16];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_alu_res;
  logic [3:0]        r_flags;

  logic [1:0]        w_cls;
  logic [1:0]        w_op;
  logic [3:0]        w_rd;
  logic [3:0]        w_rn;
  logic [3:0]        w_rm;
  logic [11:0]       w_imm12;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [PC_W-1:0]   w_pc_off;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_pc_br;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;

  assign w_cls   = r_ir[23:22];
  assign w_op    = r_ir[21:20];
  assign w_rd    = r_ir[19:16];
  assign w_rn    = r_ir[15:12];
  assign w_rm    = r_ir[11:8];
  assign w_imm12 = r_ir[11:0];

  assign w_imm_sext = DATA_W'($signed(w_imm12));
  assign w_pc_off   = PC_W'($signed(w_imm12));
  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_pc_br    = r_pc + w_pc_off;

  assign w_rd_a   = (w_rn == 4'd0) ? '0 : r_regs[w_rn];
  assign w_rd_b   = (w_rm == 4'd0) ? '0 : r_regs[w_rm];
  assign dbg_data = (dbg_addr == 4'd0) ? '0 : r_regs[dbg_addr];

  assign pc      = r_pc;
  assign alu_res = r_alu_res;
  assign flags   = r_flags;

  // One extra bit catches carry-out on add and borrow on sub.
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      2'b00: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_W];
        w_v   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      2'b01: begin
        w_res = w_diff[MSB:0];
        w_c   = ~w_diff[DATA_W];
        w_v   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
      end
      2'b10:   w_res = r_a & r_b;
      default: w_res = r_a | r_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    fetch_req   = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (inst_valid) w_state_nxt = S_DECODE;
      end
      S_DECODE:    w_state_nxt = (w_cls == 2'b11) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   w_state_nxt = (w_cls == 2'b10) ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: w_state_nxt = S_FETCH;
      S_HALT:      halted = 1'b1;
      default:     w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_res <= '0;
      r_flags   <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (inst_valid) r_ir <= inst;
        S_DECODE: begin
          r_a <= w_rd_a;
          r_b <= (w_cls == 2'b00) ? w_rd_b : w_imm_sext;
        end
        S_EXECUTE: begin
          // Branch tests Z left by the most recent ALU instruction.
          if (w_cls == 2'b10) begin
            r_pc <= r_flags[2] ? w_pc_br : w_pc_inc;
          end else begin
            r_alu_res <= w_res;
            r_flags   <= {w_res[MSB], (w_res == '0), w_c, w_v};
          end
        end
        S_WRITEBACK: r_pc <= w_pc_inc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if ((r_state == S_WRITEBACK) && (w_rd != 4'd0)) begin
      r_regs[w_rd] <= r_alu_res;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: a 24-bit and a 12-bit instance run the same
// instruction stream and are checked against a per-width arithmetic model.
module tb_multicycle_datapath;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [23:0] inst;
  logic [3:0]  dbg_addr;

  logic        fetch_req0, fetch_req1, halted0, halted1;
  logic [15:0] pc0, pc1;
  logic [23:0] alu0, dbg0;
  logic [11:0] alu1, dbg1;
  logic [3:0]  flags0, flags1;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_datapath #(.DATA_W(24), .PC_W(16)) u_dut24 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req0), .inst_valid(inst_valid),
    .inst(inst), .pc(pc0), .alu_res(alu0), .flags(flags0), .halted(halted0),
    .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );

  multicycle_datapath #(.DATA_W(12), .PC_W(16)) u_dut12 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req1), .inst_valid(inst_valid),
    .inst(inst), .pc(pc1), .alu_res(alu1), .flags(flags1), .halted(halted1),
    .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state, index 0 = 24-bit instance, 1 = 12-bit instance.
  longint m_regs [2][16];
  longint m_pc   [2];
  longint m_alu  [2];
  int     m_flags[2];
  bit     m_halt [2];

  function automatic longint act_pc(int k);    return (k == 0) ? longint'(pc0) : longint'(pc1); endfunction
  function automatic longint act_alu(int k);   return (k == 0) ? longint'(alu0) : longint'(alu1); endfunction
  function automatic longint act_flags(int k); return (k == 0) ? longint'(flags0) : longint'(flags1); endfunction
  function automatic longint act_halt(int k);  return (k == 0) ? longint'(halted0) : longint'(halted1); endfunction
  function automatic longint act_freq(int k);  return (k == 0) ? longint'(fetch_req0) : longint'(fetch_req1); endfunction
  function automatic longint act_dbg(int k);   return (k == 0) ? longint'(dbg0) : longint'(dbg1); endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) m_regs[k][r] = 0;
      m_pc[k] = 0; m_alu[k] = 0; m_flags[k] = 0; m_halt[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic [23:0] in);
    int     w    = (k == 0) ? 24 : 12;
    longint full = longint'(1) << w;
    longint half = longint'(1) << (w - 1);
    longint imm, a, b, sa, sb, sv, r;
    int     n, z, c, v;
    imm = in[11] ? longint'(in[11:0]) - 4096 : longint'(in[11:0]);
    a   = m_regs[k][in[15:12]];
    b   = (in[23:22] == 2'b00) ? m_regs[k][in[11:8]] : (imm & (full - 1));
    sa  = (a >= half) ? a - full : a;
    sb  = (b >= half) ? b - full : b;
    c = 0; v = 0; r = 0;
    if (in[23:22] == 2'b11) begin
      m_halt[k] = 1'b1;
    end else if (in[23:22] == 2'b10) begin
      if ((m_flags[k] & 4) != 0) m_pc[k] = (m_pc[k] + imm) & 65535;
      else                       m_pc[k] = (m_pc[k] + 1) & 65535;
    end else begin
      case (in[21:20])
        2'b00: begin r = a + b; c = (r >= full) ? 1 : 0; sv = sa + sb; end
        2'b01: begin r = a - b; c = (a >= b) ? 1 : 0;    sv = sa - sb; end
        2'b10: begin r = a & b; sv = 0; end
        default: begin r = a | b; sv = 0; end
      endcase
      v = (sv >= half || sv < -half) ? 1 : 0;
      r = r & (full - 1);
      n = (r >= half) ? 1 : 0;
      z = (r == 0) ? 1 : 0;
      m_alu[k]   = r;
      m_flags[k] = n * 8 + z * 4 + c * 2 + v;
      if (in[19:16] != 4'd0) m_regs[k][in[19:16]] = r;
      m_pc[k] = (m_pc[k] + 1) & 65535;
    end
  endtask

  task automatic check_state(input int k);
    string p = (k == 0) ? "dut24" : "dut12";
    check({p, " pc"},        act_pc(k),    m_pc[k]);
    check({p, " alu_res"},   act_alu(k),   m_alu[k]);
    check({p, " flags"},     act_flags(k), longint'(m_flags[k]));
    check({p, " halted"},    act_halt(k),  longint'(m_halt[k]));
    check({p, " fetch_req"}, act_freq(k),  m_halt[k] ? 0 : 1);
  endtask

  task automatic check_dbg(input logic [3:0] addr);
    dbg_addr = addr;
    #1;
    for (int k = 0; k < 2; k++)
      check((k == 0) ? "dut24 dbg_data" : "dut12 dbg_data", act_dbg(k), m_regs[k][addr]);
  endtask

  task automatic do_reset();
    rst = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Entered just after a negedge with both DUTs in FETCH.
  task automatic issue(input logic [23:0] in, input int stall);
    int cyc;
    int exp_cyc;
    exp_cyc = (in[23:22] == 2'b11) ? 2 : (in[23:22] == 2'b10) ? 3 : 4;
    for (int s = 0; s < stall; s++) begin
      inst_valid = 1'b0; inst = 24'($urandom);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("stall pc", act_pc(k), m_pc[k]);
        check("stall fetch_req", act_freq(k), 1);
      end
    end
    inst_valid = 1'b1; inst = in;
    @(negedge clk);
    inst_valid = 1'($urandom); inst = 24'($urandom);
    cyc = 1;
    while (!(fetch_req0 || halted0) && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    inst_valid = 1'b0;
    check("latency", cyc, exp_cyc);
    for (int k = 0; k < 2; k++) begin
      model_step(k, in);
      check_state(k);
    end
    check_dbg(in[19:16]);
  endtask

  typedef struct {
    logic [23:0] inst;
    int          stall;
    longint      pc;
    longint      alu;
    logic [3:0]  flg;
    logic [3:0]  daddr;
    longint      dval;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [23:0] rin;
    // Expected values for the 12-bit instance; flags are {N,Z,C,V}.
    tbl[0]  = '{24'h410005, 0, 1, 'h005, 4'b0000, 4'd1, 'h005};
    tbl[1]  = '{24'h121100, 2, 2, 'h000, 4'b0110, 4'd2, 'h000};
    tbl[2]  = '{24'h800FFE, 0, 0, 'h000, 4'b0110, 4'd1, 'h005};
    tbl[3]  = '{24'h4107FF, 5, 1, 'h7FF, 4'b0000, 4'd1, 'h7FF};
    tbl[4]  = '{24'h021100, 0, 2, 'hFFE, 4'b1001, 4'd2, 'hFFE};
    tbl[5]  = '{24'h800FFE, 1, 3, 'hFFE, 4'b1001, 4'd2, 'hFFE};
    tbl[6]  = '{24'h430FFF, 0, 4, 'hFFF, 4'b1000, 4'd3, 'hFFF};
    tbl[7]  = '{24'h043300, 3, 5, 'hFFE, 4'b1010, 4'd4, 'hFFE};
    tbl[8]  = '{24'h400007, 0, 6, 'h007, 4'b0000, 4'd0, 'h000};
    tbl[9]  = '{24'h6530F0, 0, 7, 'h0F0, 4'b0000, 4'd5, 'h0F0};
    tbl[10] = '{24'h365100, 1, 8, 'h7FF, 4'b0000, 4'd6, 'h7FF};
    tbl[11] = '{24'h171300, 0, 9, 'h800, 4'b1001, 4'd7, 'h800};

    rst = 1'b0; inst_valid = 1'b0; inst = '0; dbg_addr = '0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) check_state(k);
    @(negedge clk);
    do_reset();

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) check_state(k);
    end

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].inst, tbl[i].stall);
      check("tbl pc", longint'(pc1), tbl[i].pc);
      check("tbl alu_res", longint'(alu1), tbl[i].alu);
      check("tbl flags", longint'(flags1), longint'(tbl[i].flg));
      dbg_addr = tbl[i].daddr;
      #1;
      check("tbl dbg_data", longint'(dbg1), tbl[i].dval);
    end

    for (int i = 0; i < 60; i++) begin
      rin = 24'($urandom);
      rin[23:22] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        rin[23:20] = 4'b0001;
        rin[11:8]  = rin[15:12];
      end
      issue(rin, $urandom_range(0, 3));
      check_dbg(4'($urandom_range(0, 15)));
    end

    // pc wrap in both directions
    do_reset();
    issue(24'h110000, 0);
    issue(24'h800FFE, 0);
    check("wrap back", longint'(pc0), 'hFFFF);
    issue(24'h410001, 0);
    check("wrap fwd", longint'(pc0), 0);

    // reset while an ADDI sits in EXECUTE
    issue(24'h490003, 1);
    inst_valid = 1'b1; inst = 24'h49000A;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) check_state(k);
    check_dbg(4'd9);
    @(negedge clk);
    rst = 1'b1;

    issue(24'h400007, 2);
    check_dbg(4'd0);
    issue(24'hC00000, 0);
    for (int c = 0; c < 12; c++) begin
      inst_valid = 1'b1; inst = 24'($urandom);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("halt halted", act_halt(k), 1);
        check("halt fetch_req", act_freq(k), 0);
        check("halt pc", act_pc(k), m_pc[k]);
      end
    end
    inst_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath: same 24-bit instruction format, register file, sign extension and 4-op ALU.
- An internal controller FSM sequences each instruction over several cycles.
- Instructions are fetched from an external instruction memory with a variable-latency request/valid handshake.
- Adds a registered flag set, PC-relative branch-if-zero, HALT, and a debug register read port.

Parameters:
- DATA_W, 24, datapath/register width (≥12); immediates sign-extended to DATA_W.
- PC_W, 16, program counter width; PC arithmetic wraps mod 2^PC_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  out  1  high while in FETCH; requests the instruction at pc.
- inst_valid  in  1  inst holds a valid instruction; sampled only in FETCH.
- inst  in  24  instruction word.
- pc  out  PC_W  program counter.
- alu_res  out  DATA_W  last registered ALU result.
- flags  out  4  {negative, zero, carry, overflow}, registered.
- halted  out  1  high in HALT.
- dbg_addr  in  4  debug register index.
- dbg_data  out  DATA_W  combinational read of regs[dbg_addr]; r0 reads 0.

Behaviour:
- Instruction fields:
  - [23:22] class: 00 ALU reg, 01 ALU imm, 10 branch-if-zero, 11 HALT.
  - [21:20] ALU op: 00 add, 01 sub, 10 and, 11 or.
  - [19:16] rd, [15:12] rn, [11:8] rm, [11:0] imm12.
- Register file: 16 × DATA_W, two reads and one write. r0 is hardwired to 0; writes to r0 are dropped.
- Reset (async, rst=0), from any state, mid-instruction included:
  - state=FETCH, pc=0, IR=0, all registers=0, alu_res=0, flags=0, halted=0.
  - fetch_req=1 as soon as reset releases.
- FSM states: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH:
  - fetch_req=1.
  - inst_valid=0: stay in FETCH; pc and all state hold.
  - inst_valid=1: latch IR=inst, go to DECODE.
- DECODE:
  - A=regs[rn]; B=regs[rm] for class 00, sext(imm12) for class 01/10.
  - Class 11 → HALT; otherwise → EXECUTE.
- EXECUTE, ALU classes:
  - alu_res = A op B, mod 2^DATA_W. Update flags, then go to WRITEBACK.
  - N = MSB of result; Z = (result==0).
  - add: C = carry-out, V = signed overflow.
  - sub (A−B): C = 1 when no borrow (A ≥ B unsigned), V = signed overflow.
  - and/or: C=0, V=0.
- EXECUTE, branch class:
  - If the registered Z from the most recent ALU instruction is 1: pc = pc + sext(imm12), truncated to PC_W. Otherwise pc = pc+1.
  - Flags and alu_res unchanged. Next state FETCH.
- WRITEBACK: regs[rd] = alu_res (dropped if rd=0), pc = pc+1, next state FETCH.
- HALT:
  - Absorbing; only reset exits.
  - halted=1, fetch_req=0, pc frozen.
- inst_valid outside FETCH is ignored.
- Latency:
  - ALU instruction: 4 cycles from the accepting FETCH edge through WRITEBACK, with zero-wait memory.
  - Branch: 3 cycles.
  - HALT: halted=1 two cycles after acceptance.
- Wrap-around: pc=2^PC_W−1 incremented gives 0. Branch offsets wrap identically.
- Register writes and pc update occur on the same edge. dbg_data reflects the new value in the following cycle.

Test Plan:
1. Reset/idle: hold rst=0 then release with inst_valid=0 for 5 cycles → pc=0, fetch_req=1, halted=0, flags=0000, state stays FETCH.
2. ADDI: inst=0x410005 (r1=r0+5) → after 4 cycles dbg_addr=1 gives 5, alu_res=5, pc=1, flags N=0,Z=0.
3. SUB to zero: with r1=5, inst=0x121100 (r2=r1−r1) → r2=0, Z=1, C=1, V=0, pc increments.
4. Branch taken/not taken:
   - Z=1 at pc=2, inst=0x800FFE (offset −2) → pc=0 after 3 cycles.
   - Repeat with Z=0 → pc=3.
5. Flags at DATA_W=12:
   - ADDI imm 0x7FF into r1, then add r2=r1+r1 → r2=0xFFE, N=1, V=1, C=0.
   - ADDI imm 0xFFF into r3 (−1), then add r4=r3+r3 → 0xFFE, C=1, V=0.
6. Halt/stall/reset:
   - Stall inst_valid low 5 cycles in FETCH → pc stable.
   - inst=0xC00000 → halted=1, fetch_req=0 for 10+ cycles.
   - Assert rst during EXECUTE of an ADDI → pc=0, target register still 0, halted=0 immediately.
   - rd=0 write (0x400007) → dbg r0 reads 0.
